// File: rtl/spi_pkg.sv
// Shared constants and state type for the SPI frame receiver.
// Imported by spi_sync_edge and spi_frame_receiver.
package spi_pkg;

    localparam int SPI_FRAME_BITS  = 32;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_rx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with one extra register for rise/fall pulses.
// RESET_VAL sets the idle level of the synced signal.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES    = SPI_SYNC_STAGES,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 peripheral receiver: MSB-first frames to a valid/ready word.
// Define SPI_RX_MISO_EN to echo the last received word on spi_miso.
module spi_frame_receiver
    import spi_pkg::*;
#(
    parameter int FRAME_BITS  = SPI_FRAME_BITS,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_clk,
    input  logic                  spi_cs,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  frame_err
);

    localparam int             CW   = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(FRAME_BITS - 1);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (spi_clk),
        .q    (sck_s),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (spi_cs),
        .q    (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_sync <= '0;
        else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end

    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    spi_rx_state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [FRAME_BITS-1:0] shift_q;
    logic [CW-1:0]         bit_cnt;
    logic                  done_q;
    logic                  abort_q;
    logic                  sample;

    assign sample = (state_q == ACTIVE) && sck_rise;

    // Completion and abort are registered one cycle before they act
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= sample && (bit_cnt == LAST);
            abort_q <= (state_q == ACTIVE) && cs_rise && (bit_cnt != '0);
            if ((state_q == IDLE) && cs_fall) begin
                bit_cnt <= '0;
            end else if (sample) begin
                shift_q <= {shift_q[FRAME_BITS-2:0], mosi_s};
                bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= abort_q;
            if (done_q) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_q;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_RX_MISO_EN
    logic [FRAME_BITS-1:0] tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
        end else if ((state_q == IDLE) && cs_fall) begin
            tx_q <= rx_data;
        end else if ((state_q == ACTIVE) && sck_fall) begin
            tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign spi_miso = (state_q == ACTIVE) ? tx_q[FRAME_BITS-1] : 1'b0;

    logic unused_sync;
    assign unused_sync = sck_s ^ cs_s;
`else
    assign spi_miso = 1'b0;

    logic unused_sync;
    assign unused_sync = sck_s ^ cs_s ^ sck_fall;
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Scoreboard bench for spi_frame_receiver: random and directed SPI frames.
module tb_spi_frame_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        rx_overrun;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    int valid_cycles = 0;
    logic [31:0] exp_q[$];

    spi_frame_receiver #(.FRAME_BITS(32), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_overrun(rx_overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Monitor: every handshake must match the oldest expected frame
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_seen++;
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL handshake: got %h, required no frame", rx_data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        failures++;
                        $display("FAIL handshake: got %h, required %h", rx_data, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cs_begin();
        spi_cs = 1'b0;
        tick(8);
    endtask

    task automatic cs_end();
        tick(8);
        spi_cs = 1'b1;
        tick(8);
    endtask

    // Mode 0: MOSI set while SCK low, MISO sampled just before SCK rises
    task automatic shift_bits(input logic [31:0] d, input int n, output logic [31:0] mw);
        mw = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = d[31-i];
            tick(4);
            mw = {mw[30:0], spi_miso};
            spi_clk = 1'b1;
            tick(4);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] d);
        logic [31:0] mw;
        cs_begin();
        shift_bits(d, 32, mw);
        cs_end();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            tick(1);
            t++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    logic        rand_ready = 1'b0;
    logic [31:0] mw;
    logic [31:0] f;
    int          e0;
    int          v0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        tick(3);
        check("reset_data", rx_data, 32'd0);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_overrun", 32'(rx_overrun), 32'd0);
        check("reset_err", 32'(frame_err), 32'd0);
        check("reset_miso", 32'(spi_miso), 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Single frame with a ready consumer
        rx_ready = 1'b1;
        v0 = valid_cycles;
        exp_q.push_back(32'h0000_00A5);
        send_frame(32'h0000_00A5);
        drain();
        check("single_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("single_overrun", 32'(rx_overrun), 32'd0);

        // Aborted frame after 10 bits
        e0 = err_seen;
        cs_begin();
        shift_bits(32'hFFFF_FFFF, 10, mw);
        cs_end();
        tick(6);
        check("abort_err_pulses", 32'(err_seen - e0), 32'd1);
        check("abort_valid", 32'(rx_valid), 32'd0);
        exp_q.push_back(32'h0000_0001);
        send_frame(32'h0000_0001);
        drain();

        // Streaming two frames under one CS
        e0 = err_seen;
        exp_q.push_back(32'hCAFE_F00D);
        exp_q.push_back(32'h0BAD_C0DE);
        cs_begin();
        shift_bits(32'hCAFE_F00D, 32, mw);
        shift_bits(32'h0BAD_C0DE, 32, mw);
        cs_end();
        drain();
        check("stream_err", 32'(err_seen - e0), 32'd0);

        // Random frames, random consumer backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            f = $urandom;
            exp_q.push_back(f);
            if (i % 2 == 0) begin
                send_frame(f);
            end else begin
                cs_begin();
                shift_bits(f, 32, mw);
                f = $urandom;
                exp_q.push_back(f);
                shift_bits(f, 32, mw);
                cs_end();
            end
        end
        drain();
        rand_ready = 1'b0;
        tick(1);
        rx_ready = 1'b0;
        check("random_overrun", 32'(rx_overrun), 32'd0);

        // Two frames with no consumer: second is dropped, overrun sticks
        send_frame(32'h1234_5678);
        send_frame(32'hDEAD_BEEF);
        tick(4);
        check("noready_data", rx_data, 32'h1234_5678);
        check("noready_valid", 32'(rx_valid), 32'd1);
        check("noready_overrun", 32'(rx_overrun), 32'd1);
        exp_q.push_back(32'h1234_5678);
        rx_ready = 1'b1;
        drain();
        tick(4);
        check("noready_overrun_sticky", 32'(rx_overrun), 32'd1);

        // Reset in the middle of a frame
        cs_begin();
        shift_bits(32'h5A5A_5A5A, 16, mw);
        rst_n = 1'b0;
        #1;
        check("midreset_data", rx_data, 32'd0);
        check("midreset_valid", 32'(rx_valid), 32'd0);
        check("midreset_overrun", 32'(rx_overrun), 32'd0);
        check("midreset_miso", 32'(spi_miso), 32'd0);
        spi_cs = 1'b1;
        spi_clk = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(4);
        exp_q.push_back(32'h0000_0042);
        send_frame(32'h0000_0042);
        drain();

        // MISO echo of the previously received word
        exp_q.push_back(32'h0000_00A5);
        send_frame(32'h0000_00A5);
        drain();
        f = $urandom;
        exp_q.push_back(f);
        cs_begin();
        shift_bits(f, 32, mw);
        cs_end();
        drain();
`ifdef SPI_RX_MISO_EN
        check("miso_echo", mw, 32'h0000_00A5);
`else
        check("miso_zero", mw, 32'd0);
`endif
        check("final_err_total", 32'(err_seen), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Peripheral-side SPI receiver that accepts the frames produced by `spi_driver` and returns them to the core clock domain as parallel words. It synchronizes `spi_clk`, `spi_cs` and `spi_mosi` into `clk`, shifts data in MSB-first, and presents each completed frame through a valid/ready handshake with overrun and framing-error flags. It sits at the far end of the reaction-timer SPI link, for example in a companion display or logging tile, or in loopback test logic.

## Interface
- `FRAME_BITS`, default 32: bits per frame. Must be ≥ 2.
- `SYNC_STAGES`, default 2: synchronizer flops per SPI input. Must be ≥ 2.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `spi_clk` in 1: SPI serial clock, mode 0.
- `spi_cs` in 1: chip select, active-low.
- `spi_mosi` in 1: serial data from the controller.
- `spi_miso` out 1: serial data to the controller (see Configuration).
- `rx_data` out `FRAME_BITS`: last completed frame.
- `rx_valid` out 1: `rx_data` holds an unconsumed frame.
- `rx_ready` in 1: consumer accepts `rx_data` when asserted together with `rx_valid`.
- `rx_overrun` out 1: sticky flag, cleared by reset only.
- `frame_err` out 1: single-cycle pulse on an aborted frame.

## Operation
- Each SPI input passes through `SYNC_STAGES` flops. A further register provides edge detection of synced SCK and CS.
- States:
  - IDLE: synced CS high.
  - ACTIVE: synced CS low.
- Transitions:
  - IDLE→ACTIVE on a CS falling edge. The bit counter clears to 0.
  - ACTIVE→IDLE on a CS rising edge.
- Shifting in ACTIVE:
  - On each synced SCK rising edge: `shift <= {shift[FRAME_BITS-2:0], mosi_s}` and `bit_cnt++`.
  - When `bit_cnt` reaches `FRAME_BITS-1` and a sample occurs, the frame is complete. `bit_cnt` wraps to 0, so continuous streaming under one CS yields consecutive frames.
- Frame completion:
  - If `rx_valid`=0, or `rx_valid`&`rx_ready` in the same cycle: load `rx_data`, then `rx_valid`=1.
  - Otherwise: set `rx_overrun`, keep the old `rx_data`, and discard the new frame.
- Consumption: `rx_valid` clears the cycle after `rx_valid`&`rx_ready`, unless a completion reloads it in that same cycle.
- Abort: a CS rising edge with `bit_cnt`≠0 pulses `frame_err` for 1 cycle. The partial frame is discarded and `rx_data`/`rx_valid` are unchanged.
- SCK edges while IDLE are ignored.
- Async reset clears every flop, including synchronizers, shift register and counter. A frame in flight at reset is lost, and the first frame after reset begins at the next CS falling edge.
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_overrun`=0, `frame_err`=0, `spi_miso`=0. The synced CS resets to 1 (IDLE).

## Timing
- A bit is sampled `SYNC_STAGES`+1 `clk` cycles after the SCK rising edge at the pin.
- `rx_valid` rises `SYNC_STAGES`+2 cycles after the final SCK rising edge.
- `frame_err` pulses `SYNC_STAGES`+2 cycles after the CS rising edge.
- Constraints on the SPI controller:
  - SCK high and low phases each ≥ `SYNC_STAGES`+1 `clk` periods.
  - CS setup to the first SCK rise ≥ `SYNC_STAGES`+1 `clk` periods.
  - CS hold after the last SCK fall ≥ `SYNC_STAGES`+1 `clk` periods.
  - MOSI stable around the SCK rise for ≥ `SYNC_STAGES`+1 `clk` periods.
- Throughput: one frame per `FRAME_BITS` SCK periods. The consumer has at least that long to assert `rx_ready` before an overrun.

## Configuration
- `SPI_RX_MISO_EN` defined:
  - At the CS falling edge, a transmit register loads the current `rx_data`.
  - `spi_miso` drives the transmit register MSB, changing on each synced SCK falling edge, MSB-first.
  - `spi_miso`=0 while IDLE.
- `SPI_RX_MISO_EN` undefined: `spi_miso` is constant 0 and no transmit register exists.

## Structure
- Shared package `spi_pkg`:
  - Default frame width constant (32).
  - Synchronizer depth constant (2).
  - State enum `spi_rx_state_t` {IDLE, ACTIVE}.
- Sub-module `spi_sync_edge`: N-stage synchronizer plus rise/fall edge pulses. Instantiated once each for SCK and CS; MOSI uses the synchronizer only.

## Test plan
- **Single frame:** frame 0x000000A5 at SCK = clk/8 with `rx_ready`=1 → `rx_valid` pulses 1 cycle, `rx_data`=0x000000A5, `rx_overrun`=0.
- **Back-to-back frames, no consumer:** frames 0x12345678 then 0xDEADBEEF with `rx_ready`=0 → `rx_data` stays 0x12345678, `rx_valid`=1, `rx_overrun`=1.
- **Aborted frame:** CS deasserted after 10 bits of 0xFFFFFFFF → one `frame_err` pulse, `rx_valid` stays 0. The next full frame 0x00000001 is received correctly.
- **Streaming:** two frames 0xCAFEF00D and 0x0BADC0DE under one CS with `rx_ready`=1 → two `rx_valid` events in order, no `frame_err`.
- **Reset mid-frame:** `rst_n` low after 16 bits → all outputs at reset values immediately. The next full frame 0x00000042 is received correctly.
- **MISO echo (`SPI_RX_MISO_EN`):** receive 0x000000A5, then clock a second frame → `spi_miso` shifts out 0x000000A5 MSB-first. Without the macro, `spi_miso` stays 0.
